// File: rtl/sar_search_pkg.sv
// Shared types and helpers for the successive-approximation search engine.
// The trial-bit mask helper is limited to operands of at most 32 bits.
package sar_search_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_e;

    // One-hot mask selecting the trial bit at position bit_idx.
    function automatic logic [31:0] trial_mask(input int unsigned bit_idx);
        return 32'd1 << bit_idx;
    endfunction

endpackage

// File: rtl/sar_search.sv
// Binary search of an externally held operand through a magnitude comparator:
// one trial bit per cycle, MSB first, stopping early on equality.
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STEP_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [WIDTH-1:0]  cmp_b,
    input  logic              cmp_result,
    input  logic              cmp_equal,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [WIDTH-1:0]  value,
    output logic [STEP_W-1:0] steps
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state, state_nxt;
    logic [WIDTH-1:0]   acc, acc_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [WIDTH-1:0]   cmp_b_nxt;
    logic               found_nxt;
    logic [WIDTH-1:0]   value_nxt;
    logic [STEP_W-1:0]  steps_nxt;
    logic [WIDTH-1:0]   new_acc;

    // Keep the trial bit only when the comparator says a is above the trial.
    assign new_acc = cmp_result ? cmp_b : acc;

    assign busy = (state == SEARCH);
    assign done = (state == DONE);

    // NOTE: every signal written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        cmp_b_nxt = cmp_b;
        found_nxt = found;
        value_nxt = value;
        steps_nxt = steps;

        case (state)
            IDLE: begin
                cmp_b_nxt = '0;
                if (start) begin
                    acc_nxt   = '0;
                    idx_nxt   = IDX_W'(WIDTH - 1);
                    cmp_b_nxt = WIDTH'(trial_mask(WIDTH - 1));
                    steps_nxt = '0;
                    found_nxt = 1'b0;
                    value_nxt = '0;
                    state_nxt = SEARCH;
                end
            end

            SEARCH: begin
                steps_nxt = steps + STEP_W'(1);
                if (cmp_equal) begin
                    found_nxt = 1'b1;
                    value_nxt = cmp_b;
                    state_nxt = DONE;
                end else begin
                    acc_nxt = new_acc;
                    if (idx != '0) begin
                        idx_nxt   = idx - IDX_W'(1);
                        cmp_b_nxt = new_acc | WIDTH'(trial_mask(32'(idx - IDX_W'(1))));
                    end else begin
                        // Bits exhausted without equality: a==0 or an inconsistent comparator.
                        found_nxt = 1'b0;
                        value_nxt = new_acc;
                        state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                cmp_b_nxt = '0;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            idx   <= IDX_W'(WIDTH - 1);
            cmp_b <= '0;
            found <= 1'b0;
            value <= '0;
            steps <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            idx   <= idx_nxt;
            cmp_b <= cmp_b_nxt;
            found <= found_nxt;
            value <= value_nxt;
            steps <= steps_nxt;
        end
    end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search engine: the initiating side of the team's 8-bit magnitude comparator interface.
- Drives the comparator's `b` operand with trial values and consumes its `{equal,result}` outputs. The `a` operand is an unknown value held externally.
- Binary-searches `a` one bit per cycle, MSB first, and reports the recovered value, a found flag and the step count.
- Used wherever a value is only observable through a compare, e.g. threshold discovery or DAC/ADC-style trimming loops.

Parameters:
- WIDTH, 8, operand width; must match the comparator.
- STEP_W, $clog2(WIDTH+1), width of the step counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a search; sampled only in IDLE.
- cmp_b  output  WIDTH  trial value driven to the comparator `b` input (registered).
- cmp_result  input  1  comparator `result`: 1 when a > cmp_b.
- cmp_equal  input  1  comparator `equal`: 1 when a == cmp_b.
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when the search ends.
- found  output  1  1 if equality was observed; valid from done, held until the next start.
- value  output  WIDTH  recovered value; valid from done, held until the next start.
- steps  output  STEP_W  number of compare cycles used; valid from done, held until the next start.

Behaviour:
- One clock (`clk`); reset (`rst_n`) is asynchronous and active-low.
- Reset values: cmp_b=0, busy=0, done=0, found=0, value=0, steps=0. Internal state: state=IDLE, acc=0, bit index=WIDTH-1.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - cmp_b=0.
  - On start=1: acc<=0, idx<=WIDTH-1, cmp_b<=1<<(WIDTH-1), step count<=0, go to SEARCH.
  - On the same edge, clear found/value/steps.
- SEARCH:
  - The comparator is combinational, so its outputs are sampled on the same cycle cmp_b is presented. One step per cycle.
  - Step count increments every SEARCH cycle.
  - cmp_equal=1 (priority over cmp_result): found<=1, value<=cmp_b, go to DONE.
  - Else cmp_result=1 (a > trial): acc<=cmp_b (keep the trial bit).
  - Else (a < trial): acc unchanged (drop the trial bit).
  - If idx>0 and not equal: idx<=idx-1, cmp_b<=new_acc | (1<<(idx-1)).
  - If idx==0 and not equal: found<=0, value<=new_acc, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, cmp_b<=0, go to IDLE. Results hold until the next start.
- Latency:
  - start sampled at edge 0; first trial visible after edge 0.
  - Equality at trial bit k (k=WIDTH-1..0) gives steps=WIDTH-k; done is high in the cycle after edge WIDTH-k.
  - Maximum is WIDTH steps. A consistent comparator sees equality exactly at the lowest set bit of `a`.
  - a==0 never produces equality: found=0, value=0, steps=WIDTH.
- busy is high exactly in SEARCH cycles; done and busy are never both high.
- start while busy or in DONE is ignored (no queueing). start held high re-launches in the first IDLE cycle after DONE.
- Inconsistent comparator (cmp_result=1 at idx==0 without equal): still terminate with found=0, value=acc|1. No hang.
- `a` changing mid-search: the search is not restarted; the result reflects the bitwise samples taken.
- Reset asserted mid-search: all outputs and state return to reset values immediately (asynchronous). No done pulse is emitted.
- All arithmetic is unsigned WIDTH-bit; no carries or wrap-around are possible.

Decomposition:
- Package sar_search_pkg holds: state enum (IDLE, SEARCH, DONE), default WIDTH=8, and a function for the trial-bit mask.
- No sub-module: a single FSM plus datapath registers.
- The testbench instantiates the team's existing 8-bit comparator as the responder, with `a` driven by the bench.

Test Plan:
- a=0x80, start pulse → cmp_b=0x80 on step 1, done at cycle 2, found=1, value=0x80, steps=1.
- a=0x50 → trials 0x80, 0x40, 0x60, 0x50; found=1, value=0x50, steps=4.
- a=0xA5 and a=0x01 → found=1, value matches a, steps=8, busy high for 8 cycles.
- a=0x00 → trials 0x80, 0x40, …, 0x01; found=0, value=0x00, steps=8.
- start re-pulsed during SEARCH with a=0x50 → ignored, single done, same result; start held high → back-to-back searches, one-cycle IDLE gap.
- rst_n low at step 3 of a=0xA5 search → all outputs 0 immediately, no done. Fresh start after release → correct result, steps=8.
